// File: rtl/cpu_load_store_unit_pkg.sv
// Shared definitions for the load/store unit: MIPS memory opcodes, exception
// codes, FSM state type and lane/alignment helpers.
package cpu_load_store_unit_pkg;

  localparam logic [5:0] EXE_LB  = 6'h20;
  localparam logic [5:0] EXE_LH  = 6'h21;
  localparam logic [5:0] EXE_LW  = 6'h23;
  localparam logic [5:0] EXE_LBU = 6'h24;
  localparam logic [5:0] EXE_LHU = 6'h25;
  localparam logic [5:0] EXE_SB  = 6'h28;
  localparam logic [5:0] EXE_SH  = 6'h29;
  localparam logic [5:0] EXE_SW  = 6'h2B;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic {
    LSU_IDLE,
    LSU_ACCESS
  } lsu_state_e;

  function automatic logic is_load(input logic [5:0] op);
    return op[5:3] == 3'b100;
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op[5:3] == 3'b101;
  endfunction

  // opcode[1:0] encodes access size: 00 byte, 01 half, otherwise word.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [5:0] op, input logic [1:0] a);
    case (op[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [5:0] op, input logic [31:0] d);
    case (op[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/cpu_load_store_unit_if.sv
// Pipeline-side and data-memory-side signals of the load/store unit.
// master: the load/store unit itself; slave: Execute/Write-back/memory side.
interface cpu_load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_opcode;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_store_data;
  logic [4:0]        in_write_reg;
  logic [31:0]       in_write_data;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  logic              out_valid;
  logic [4:0]        out_write_reg;
  logic [31:0]       out_write_data;
  logic              out_exc;
  logic [4:0]        out_exc_code;

  modport master (
    input  in_valid, in_opcode, in_addr, in_store_data, in_write_reg, in_write_data,
    input  mem_ack, mem_rdata,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output out_valid, out_write_reg, out_write_data, out_exc, out_exc_code
  );

  modport slave (
    output in_valid, in_opcode, in_addr, in_store_data, in_write_reg, in_write_data,
    output mem_ack, mem_rdata,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  out_valid, out_write_reg, out_write_data, out_exc, out_exc_code
  );

endinterface

// File: rtl/cpu_load_store_unit_align.sv
// Load data alignment: extracts the addressed byte/halfword from the read word
// and sign- or zero-extends it (opcode[2] set = unsigned variant).
// Ports: opcode_i, addr_i (byte offset), rdata_i -> data_o.
module cpu_load_align (
  input  logic [5:0]  opcode_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);
  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {addr_i, 3'b000};
    case (opcode_i[1:0])
      2'b00:   data_o = opcode_i[2] ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   data_o = opcode_i[2] ? {16'h0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/cpu_load_store_unit.sv
// Load/store stage between Execute and Write-back. Issues byte-enabled
// req/ack transfers, stalls via in_ready while a transfer is outstanding,
// aligns/extends load data and reports AdEL/AdES/DBE exceptions.
// Ports: clk, rst (sync, active high), bus (pipeline + data memory signals).
module cpu_load_store_unit
  import cpu_load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst,
  cpu_load_store_unit_if.master bus
);
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        reg_q, reg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              out_valid_q, out_valid_d;
  logic [4:0]        out_reg_q, out_reg_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_exc_q, out_exc_d;
  logic [4:0]        out_code_q, out_code_d;

  logic [31:0]       load_data;

  cpu_load_align u_align (
    .opcode_i (op_q),
    .addr_i   (addr_q[1:0]),
    .rdata_i  (bus.mem_rdata),
    .data_o   (load_data)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    reg_d       = reg_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + 1'b1;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    out_valid_d = 1'b0;
    out_reg_d   = out_reg_q;
    out_data_d  = out_data_q;
    out_exc_d   = out_exc_q;
    out_code_d  = out_code_q;

    case (state_q)
      LSU_IDLE: begin
        if (bus.in_valid) begin
          if (is_load(bus.in_opcode) || is_store(bus.in_opcode)) begin
            if (is_misaligned(bus.in_opcode, bus.in_addr[1:0])) begin
              out_valid_d = 1'b1;
              out_exc_d   = 1'b1;
              out_code_d  = is_load(bus.in_opcode) ? EXC_ADEL : EXC_ADES;
              out_reg_d   = '0;
              out_data_d  = 32'(bus.in_addr);
            end else begin
              state_d     = LSU_ACCESS;
              op_d        = bus.in_opcode;
              addr_d      = bus.in_addr;
              reg_d       = bus.in_write_reg;
              cnt_d       = '0;
              mem_req_d   = 1'b1;
              mem_we_d    = is_store(bus.in_opcode);
              mem_addr_d  = {bus.in_addr[ADDR_W-1:2], 2'b00};
              mem_be_d    = lane_be(bus.in_opcode, bus.in_addr[1:0]);
              mem_wdata_d = lane_wdata(bus.in_opcode, bus.in_store_data);
            end
          end else begin
            out_valid_d = 1'b1;
            out_exc_d   = 1'b0;
            out_code_d  = '0;
            out_reg_d   = bus.in_write_reg;
            out_data_d  = bus.in_write_data;
          end
        end
      end

      LSU_ACCESS: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (bus.mem_ack) begin
          state_d     = LSU_IDLE;
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          out_exc_d   = 1'b0;
          out_code_d  = '0;
          if (is_load(op_q)) begin
            out_reg_d  = reg_q;
            out_data_d = load_data;
          end else begin
            out_reg_d  = '0;
            out_data_d = '0;
          end
        end else if (TIMEOUT != 0 && cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d     = LSU_IDLE;
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          out_exc_d   = 1'b1;
          out_code_d  = EXC_DBE;
          out_reg_d   = '0;
          out_data_d  = 32'(addr_q);
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      reg_q       <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      out_valid_q <= 1'b0;
      out_reg_q   <= '0;
      out_data_q  <= '0;
      out_exc_q   <= 1'b0;
      out_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      reg_q       <= reg_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      out_valid_q <= out_valid_d;
      out_reg_q   <= out_reg_d;
      out_data_q  <= out_data_d;
      out_exc_q   <= out_exc_d;
      out_code_q  <= out_code_d;
    end
  end

  assign bus.in_ready       = (state_q == LSU_IDLE) & ~rst;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_be         = mem_be_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_write_reg  = out_reg_q;
  assign bus.out_write_data = out_data_q;
  assign bus.out_exc        = out_exc_q;
  assign bus.out_exc_code   = out_code_q;

endmodule

// File: tb/tb_cpu_load_store_unit.sv
// Self-checking bench for cpu_load_store_unit (TIMEOUT = 4). Expected
// write-back results are queued when an op is driven and compared when
// out_valid appears; memory-side signals are checked inline per scenario.
module tb_cpu_load_store_unit;

  typedef struct {
    logic [4:0]  wreg;
    logic [31:0] data;
    logic        exc;
    logic [4:0]  code;
    bit          chk_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_load_store_unit_if #(.ADDR_W(32)) bus ();

  cpu_load_store_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Result scoreboard: every out_valid pulse must match the oldest queued entry.
  always @(negedge clk) begin
    if (mon_en && bus.out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got reg=%0d data=%h exc=%b code=%0d",
                 bus.out_write_reg, bus.out_write_data, bus.out_exc, bus.out_exc_code);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.out_write_reg !== e.wreg || (e.chk_data && bus.out_write_data !== e.data) ||
            bus.out_exc !== e.exc || bus.out_exc_code !== e.code) begin
          errors++;
          $display("FAIL result got reg=%0d data=%h exc=%b code=%0d exp reg=%0d data=%h exc=%b code=%0d",
                   bus.out_write_reg, bus.out_write_data, bus.out_exc, bus.out_exc_code,
                   e.wreg, e.data, e.exc, e.code);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [4:0] wr, input logic [31:0] wd);
    bus.in_valid      = 1'b1;
    bus.in_opcode     = op;
    bus.in_addr       = addr;
    bus.in_store_data = sd;
    bus.in_write_reg  = wr;
    bus.in_write_data = wd;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_addr = '0; bus.in_store_data = '0;
    bus.in_write_reg = '0; bus.in_write_data = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready);
    end
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem got req=%b we=%b addr=%h be=%b wdata=%h exp all 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata);
    end
    checks++;
    if ({bus.out_valid, bus.out_write_reg, bus.out_write_data, bus.out_exc, bus.out_exc_code} !== '0) begin
      errors++;
      $display("FAIL reset_out got v=%b reg=%0d data=%h exc=%b code=%0d exp all 0",
               bus.out_valid, bus.out_write_reg, bus.out_write_data, bus.out_exc, bus.out_exc_code);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_passthrough();
    sb.push_back('{5'd3, 32'h0000_1234, 1'b0, 5'd0, 1'b1});
    drive_op(6'h00, 32'h0, 32'h0, 5'd3, 32'h0000_1234);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL passthrough_ready got ready=%b req=%b exp 1 0", bus.in_ready, bus.mem_req);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, bus.in_ready);
      end
      bus.in_valid      = 1'b1;
      bus.in_opcode     = 6'h00 + 6'(i);
      bus.in_addr       = 32'h0;
      bus.in_write_reg  = 5'(10 + i);
      bus.in_write_data = 32'hA5A5_0000 + 32'(i);
      sb.push_back('{5'(10 + i), 32'hA5A5_0000 + 32'(i), 1'b0, 5'd0, 1'b1});
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_byte(input logic [5:0] op, input logic [31:0] exp_data);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL lb_ready_before got %b exp 1", bus.in_ready);
    end
    sb.push_back('{5'd7, exp_data, 1'b0, 5'd0, 1'b1});
    drive_op(op, 32'h1000_0003, 32'h0, 5'd7, 32'h0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'b1000 ||
          bus.mem_addr !== 32'h1000_0000 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL lb_request[%0d] got req=%b we=%b be=%b addr=%h ready=%b exp 1 0 1000 10000000 0",
                 c, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.in_ready);
      end
      if (c == 2) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h80FF_FFFF;
      end
      tick();
    end
    bus.mem_ack = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL lb_done got req=%b ready=%b exp 0 1", bus.mem_req, bus.in_ready);
    end
    tick();
  endtask

  task automatic test_load_other();
    // LH at offset 2 sign-extends the upper half.
    sb.push_back('{5'd8, 32'hFFFF_8001, 1'b0, 5'd0, 1'b1});
    drive_op(6'h21, 32'h1000_0002, 32'h0, 5'd8, 32'h0);
    checks++;
    if (bus.mem_be !== 4'b1100 || bus.mem_addr !== 32'h1000_0000) begin
      errors++; $display("FAIL lh_request got be=%b addr=%h exp 1100 10000000", bus.mem_be, bus.mem_addr);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8001_1234;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    // LW to $0 still accesses memory and reports register 0.
    sb.push_back('{5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1});
    drive_op(6'h23, 32'h1000_0004, 32'h0, 5'd0, 32'h0);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_be !== 4'b1111 || bus.mem_addr !== 32'h1000_0004) begin
      errors++;
      $display("FAIL lw_r0_request got req=%b be=%b addr=%h exp 1 1111 10000004",
               bus.mem_req, bus.mem_be, bus.mem_addr);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_store();
    sb.push_back('{5'd0, 32'h0, 1'b0, 5'd0, 1'b0});
    drive_op(6'h29, 32'h2000_0002, 32'hABCD_1234, 5'd9, 32'h0);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'b1100 ||
        bus.mem_wdata !== 32'h1234_1234 || bus.mem_addr !== 32'h2000_0000) begin
      errors++;
      $display("FAIL sh_request got req=%b we=%b be=%b wdata=%h addr=%h exp 1 1 1100 12341234 20000000",
               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr);
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL sh_min_occupancy got req=%b ready=%b exp 0 1", bus.mem_req, bus.in_ready);
    end
    tick();
  endtask

  task automatic test_misaligned();
    logic [5:0]  ops[3]   = '{6'h23, 6'h2B, 6'h21};
    logic [31:0] addrs[3] = '{32'h3000_0001, 32'h3000_0002, 32'h3000_0003};
    logic [4:0]  codes[3] = '{5'd4, 5'd5, 5'd4};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{5'd0, addrs[i], 1'b1, codes[i], 1'b1});
      drive_op(ops[i], addrs[i], 32'h0, 5'd12, 32'h0);
      checks++;
      if (bus.mem_req !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL misaligned_noreq[%0d] got req=%b ready=%b exp 0 1", i, bus.mem_req, bus.in_ready);
      end
    end
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    sb.push_back('{5'd0, 32'h4000_0000, 1'b1, 5'd7, 1'b1});
    drive_op(6'h23, 32'h4000_0000, 32'h0, 5'd4, 32'h0);
    while (bus.mem_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL timeout_req_cycles got %0d exp 4", n);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_result got valid=%b ready=%b exp 1 1", bus.out_valid, bus.in_ready);
    end
    tick();
    // Late ack in IDLE must be ignored.
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
    tick();
    bus.mem_ack = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL late_ack got valid=%b req=%b exp 0 0", bus.out_valid, bus.mem_req);
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    drive_op(6'h23, 32'h5000_0000, 32'h0, 5'd6, 32'h0);
    tick();
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL rst_mid_req_before got %b exp 1", bus.mem_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_abandon got req=%b valid=%b exp 0 0", bus.mem_req, bus.out_valid);
    end
    #1;
    sb.push_back('{5'd9, 32'h0000_8001, 1'b0, 5'd0, 1'b1});
    drive_op(6'h25, 32'h5000_0000, 32'h0, 5'd9, 32'h0);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_be !== 4'b0011) begin
      errors++; $display("FAIL lhu_request got req=%b be=%b exp 1 0011", bus.mem_req, bus.mem_be);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_8001;
    tick();
    bus.mem_ack = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_load_byte(6'h20, 32'hFFFF_FF80);
    test_load_byte(6'h24, 32'h0000_0080);
    test_load_other();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL missing_results got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
